// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the sequential 32/16 signed divider.
package div_pkg;

  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W  = 16;
  localparam int N_ITER     = 32;
  localparam int CNT_W      = $clog2(N_ITER);
  // One extra bit so the non-restoring partial remainder can go negative.
  localparam int PREM_W     = DIVISOR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 non-restoring step: shift in the next dividend bit, then
// subtract the divisor if the partial remainder is non-negative, else add it.
import div_pkg::*;

module div_step (
  input  logic [PREM_W-1:0]    prem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] dvsr_i,
  output logic [PREM_W-1:0]    prem_o,
  output logic                 q_o
);

  logic [PREM_W-1:0] shifted;

  // Shift/add-or-subtract; the quotient bit is set when the new remainder is non-negative.
  always_comb begin
    shifted = {prem_i[PREM_W-2:0], bit_i};
    if (prem_i[PREM_W-1]) begin
      prem_o = shifted + {1'b0, dvsr_i};
    end else begin
      prem_o = shifted - {1'b0, dvsr_i};
    end
    q_o = ~prem_o[PREM_W-1];
  end

endmodule

// File: rtl/seq_div32x16.sv
// Sequential signed 32/16 divider, truncating toward zero.
// State table:
//   IDLE | waiting for operands, in_ready_o high
//   ITER | 32 non-restoring steps on operand magnitudes, one per cycle
//   FIX  | restore negative remainder, apply signs, flag overflow
//   DONE | result held, out_valid_o high until out_ready_i
import div_pkg::*;

module seq_div32x16 (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DIVIDEND_W-1:0] quotient_o,
  output logic [DIVISOR_W-1:0]  remainder_o,
  output logic                  dz_o,
  output logic                  ovf_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // Dividend magnitude shifts out of the top while quotient bits shift in at the bottom.
  logic [DIVIDEND_W-1:0] dq_q, dq_d;
  logic [PREM_W-1:0]     prem_q, prem_d;
  logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
  logic                  sa_q, sa_d;
  logic                  sb_q, sb_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dz_q, dz_d;
  logic                  ovf_q, ovf_d;

  logic [PREM_W-1:0]     step_prem;
  logic                  step_q;
  logic [DIVISOR_W-1:0]  rem_mag;
  logic                  q_neg;

  div_step u_step (
    .prem_i (prem_q),
    .bit_i  (dq_q[DIVIDEND_W-1]),
    .dvsr_i (dvsr_q),
    .prem_o (step_prem),
    .q_o    (step_q)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    prem_d  = prem_q;
    dvsr_d  = dvsr_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    q_neg   = sa_q ^ sb_q;
    // Final remainder magnitude is below the divisor, so 16 bits are exact.
    rem_mag = prem_q[PREM_W-1] ? (prem_q[DIVISOR_W-1:0] + dvsr_q) : prem_q[DIVISOR_W-1:0];

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          sa_d   = dividend_i[DIVIDEND_W-1];
          sb_d   = divisor_i[DIVISOR_W-1];
          dq_d   = dividend_i[DIVIDEND_W-1] ? (~dividend_i + 1'b1) : dividend_i;
          dvsr_d = divisor_i[DIVISOR_W-1] ? (~divisor_i + 1'b1) : divisor_i;
          prem_d = '0;
          cnt_d  = '0;
          dz_d   = 1'b0;
          ovf_d  = 1'b0;
          if (divisor_i == '0) begin
            quo_d   = '1;
            rem_d   = dividend_i[DIVISOR_W-1:0];
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = ITER;
          end
        end
      end
      ITER: begin
        prem_d = step_prem;
        dq_d   = {dq_q[DIVIDEND_W-2:0], step_q};
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        quo_d   = q_neg ? (~dq_q + 1'b1) : dq_q;
        rem_d   = sa_q ? (~rem_mag + 1'b1) : rem_mag;
        // Only -2^31 / -1 produces a positive quotient magnitude of 2^31.
        ovf_d   = ~q_neg & dq_q[DIVIDEND_W-1];
        state_d = DONE;
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      prem_q  <= '0;
      dvsr_q  <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      prem_q  <= prem_d;
      dvsr_q  <= dvsr_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign dz_o        = dz_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_seq_div32x16.sv
// Directed bench for seq_div32x16 with hand-computed expected results.
module tb_seq_div32x16;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] dividend_i;
  logic [15:0] divisor_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] quotient_o;
  logic [15:0] remainder_o;
  logic        dz_o;
  logic        ovf_o;
  logic        out_valid_o;
  logic        out_ready_i;

  int n_checks = 0;
  int n_errors = 0;

  seq_div32x16 dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .dz_o        (dz_o),
    .ovf_o       (ovf_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present operands at a negedge, accept on the next posedge, then scramble
  // the inputs and measure latency, results, hold behaviour and release.
  task automatic run_op(input logic [31:0] a, input logic [15:0] b,
                        input logic [31:0] exp_q, input logic [15:0] exp_r,
                        input logic exp_dz, input logic exp_ovf,
                        input int exp_lat, input int hold);
    int cyc;
    @(negedge clk_i);
    check("in_ready_idle", {31'd0, in_ready_o}, 32'd1);
    dividend_i = a;
    divisor_i  = b;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b1;
    dividend_i = 32'h1357_9BDF;
    divisor_i  = 16'h0003;
    @(negedge clk_i);
    cyc = 1;
    check("in_ready_busy", {31'd0, in_ready_o}, 32'd0);
    while (!out_valid_o && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    in_valid_i = 1'b0;
    check("latency", cyc, exp_lat);
    check("quotient", quotient_o, exp_q);
    check("remainder", {16'd0, remainder_o}, {16'd0, exp_r});
    check("dz", {31'd0, dz_o}, {31'd0, exp_dz});
    check("ovf", {31'd0, ovf_o}, {31'd0, exp_ovf});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check("hold_valid", {31'd0, out_valid_o}, 32'd1);
      check("hold_ready", {31'd0, in_ready_o}, 32'd0);
      check("hold_quot", quotient_o, exp_q);
      check("hold_rem", {16'd0, remainder_o}, {16'd0, exp_r});
      check("hold_flags", {30'd0, dz_o, ovf_o}, {30'd0, exp_dz, exp_ovf});
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check("release_ready", {31'd0, in_ready_o}, 32'd1);
    check("release_valid", {31'd0, out_valid_o}, 32'd0);
    check("keep_quot", quotient_o, exp_q);
  endtask

  initial begin
    int cyc;
    rst_ni      = 1'b0;
    dividend_i  = '0;
    divisor_i   = '0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_quot", quotient_o, 32'd0);
    check("rst_rem", {16'd0, remainder_o}, 32'd0);
    check("rst_flags", {30'd0, dz_o, ovf_o}, 32'd0);
    rst_ni = 1'b1;

    run_op(32'd100,        16'd7,      32'd14,         16'd2,      1'b0, 1'b0, 34, 5);
    run_op(-32'sd100,      16'd7,      32'hFFFF_FFF2,  16'hFFFE,   1'b0, 1'b0, 34, 1);
    run_op(32'd100,        16'hFFF9,   32'hFFFF_FFF2,  16'h0002,   1'b0, 1'b0, 34, 0);
    run_op(32'd1234,       16'd0,      32'hFFFF_FFFF,  16'h04D2,   1'b1, 1'b0, 1,  2);
    run_op(32'h8000_0000,  16'hFFFF,   32'h8000_0000,  16'h0000,   1'b0, 1'b1, 34, 1);
    run_op(32'hFFFF_FFF9,  16'hFFFE,   32'd3,          16'hFFFF,   1'b0, 1'b0, 34, 0);
    run_op(32'h8000_0000,  16'd1,      32'h8000_0000,  16'h0000,   1'b0, 1'b0, 34, 0);
    run_op(32'h7FFF_FFFF,  16'h7FFF,   32'h0001_0002,  16'h0001,   1'b0, 1'b0, 34, 0);
    run_op(32'h8000_0000,  16'h8000,   32'h0001_0000,  16'h0000,   1'b0, 1'b0, 34, 0);
    run_op(32'hFFFF_FFFB,  16'd0,      32'hFFFF_FFFF,  16'hFFFB,   1'b1, 1'b0, 1,  0);
    run_op(32'd0,          16'd5,      32'd0,          16'd0,      1'b0, 1'b0, 34, 0);

    // Reset in the middle of an iteration discards the operation.
    @(negedge clk_i);
    dividend_i = 32'd100;
    divisor_i  = 16'd7;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk_i);
      cyc++;
    end
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    check("midrst_in_ready", {31'd0, in_ready_o}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("midrst_quot", quotient_o, 32'd0);
    check("midrst_rem", {16'd0, remainder_o}, 32'd0);
    check("midrst_flags", {30'd0, dz_o, ovf_o}, 32'd0);
    repeat (40) begin
      @(negedge clk_i);
      check("midrst_no_output", {31'd0, out_valid_o}, 32'd0);
    end
    run_op(32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 1'b0, 34, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
